// File: rtl/apb_slave_bridge_mc_pkg.sv
// apb_bridge_pkg: shared definitions for the multi-channel APB slave bridge.
//   - bridge_state_e : FSM state encoding (IDLE/REQ/WAIT/RESP)
//   - CH_BITS()      : channel index width, clog2(n) with a minimum of 1
//   - bridge_req_t   : transfer latched in the setup phase
// The BR_* widths are the single configuration point for the latched-request
// struct; the bridge top rejects parameter overrides that disagree with them.
package apb_bridge_pkg;

    localparam int BR_DATA_W     = 32;
    localparam int BR_ADDR_W     = 12;
    localparam int BR_REGION_W   = 8;
    localparam int BR_STRB_W     = BR_DATA_W / 8;
    localparam int BR_CH_FIELD_W = BR_ADDR_W - BR_REGION_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } bridge_state_e;

    function automatic int CH_BITS(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic [BR_REGION_W-1:0]   addr;   // offset inside the channel window
        logic                     write;
        logic [BR_DATA_W-1:0]     wdata;
        logic [BR_STRB_W-1:0]     strb;
        logic [BR_CH_FIELD_W-1:0] ch;     // raw decoded channel field
    } bridge_req_t;

endpackage

// File: rtl/apb_slave_bridge_mc_if.sv
// apb_slave_bridge_mc_if: APB target-side bus bundle.
//   slave  modport : PSELx/PENABLE/PWRITE/PSTRB/PWDATA/PADDR in,
//                    PRDATA/PREADY/PSLVERR out
//   master modport : mirror image, used by whatever drives the bus
// Handshake: a transfer starts with a setup cycle (PSELx=1, PENABLE=0); the
// master then holds PSELx=1, PENABLE=1 and all request fields stable until the
// cycle in which PREADY=1 completes it. PSLVERR/PRDATA are meaningful only in
// that PREADY cycle.
interface apb_slave_bridge_mc_if
    import apb_bridge_pkg::*;
#(
    parameter int DATA_WIDTH = BR_DATA_W,
    parameter int ADDR_WIDTH = BR_ADDR_W
);
    logic                    PSELx;
    logic                    PENABLE;
    logic                    PWRITE;
    logic [DATA_WIDTH/8-1:0] PSTRB;
    logic [DATA_WIDTH-1:0]   PWDATA;
    logic [ADDR_WIDTH-1:0]   PADDR;
    logic [DATA_WIDTH-1:0]   PRDATA;
    logic                    PREADY;
    logic                    PSLVERR;

    modport slave (
        input  PSELx, PENABLE, PWRITE, PSTRB, PWDATA, PADDR,
        output PRDATA, PREADY, PSLVERR
    );

    modport master (
        output PSELx, PENABLE, PWRITE, PSTRB, PWDATA, PADDR,
        input  PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_slave_bridge_mc_timeout_ctr.sv
// apb_timeout_ctr: back-end response watchdog, compiled only when
// APB_BRIDGE_TIMEOUT_EN is defined.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : hold the count at zero (whenever no request is in flight)
//   enable   : count this cycle (request outstanding)
//   limit    : number of enabled cycles allowed
//   expired  : combinational; high in the enabled cycle that reaches limit
`ifdef APB_BRIDGE_TIMEOUT_EN
module apb_timeout_ctr #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         expired
);
    logic [W-1:0] cnt_q;

    // The cycle that would bring the count up to limit is the expiring one.
    assign expired = enable && ((cnt_q + W'(1)) == limit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && !expired) begin
            cnt_q <= cnt_q + W'(1);
        end
    end
endmodule
`endif

// File: rtl/apb_slave_bridge_mc.sv
// apb_slave_bridge_mc: APB slave that fans one target port out to NUM_CH
// register back-ends. The channel is PADDR[ADDR_WIDTH-1:REGION_BITS]; the
// selected back-end gets a one-cycle rd/wr pulse and the bridge inserts wait
// states until it answers with bk_ready.
//   PCLK, PRESET     : clock, asynchronous active-high reset
//   apb (slave)      : APB bus (see apb_slave_bridge_mc_if)
//   bk_wr_en/rd_en   : one-hot request pulses, one cycle, per channel
//   bk_addr/wdata/strb : latched offset, write data and strobes
//   bk_rdata         : packed read data, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   bk_ready/error   : per-channel completion and error (error qualified by ready)
//   dbg_state        : current FSM state (apb_bridge_pkg::bridge_state_e encoding)
// Optional feature macro: APB_BRIDGE_TIMEOUT_EN adds a TIMEOUT_CYCLES
// response watchdog that ends a silent transfer with PSLVERR=1.
module apb_slave_bridge_mc
    import apb_bridge_pkg::*;
#(
    parameter int DATA_WIDTH     = BR_DATA_W,
    parameter int ADDR_WIDTH     = BR_ADDR_W,
    parameter int NUM_CH         = 4,
    parameter int REGION_BITS    = BR_REGION_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    apb_slave_bridge_mc_if.slave         apb,
    output logic [NUM_CH-1:0]            bk_wr_en,
    output logic [NUM_CH-1:0]            bk_rd_en,
    output logic [REGION_BITS-1:0]       bk_addr,
    output logic [DATA_WIDTH-1:0]        bk_wdata,
    output logic [DATA_WIDTH/8-1:0]      bk_strb,
    input  logic [NUM_CH*DATA_WIDTH-1:0] bk_rdata,
    input  logic [NUM_CH-1:0]            bk_ready,
    input  logic [NUM_CH-1:0]            bk_error,
    output logic [1:0]                   dbg_state
);
    localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
    localparam logic [1:0] S_REQ  = 2'(ST_REQ);
    localparam logic [1:0] S_WAIT = 2'(ST_WAIT);
    localparam logic [1:0] S_RESP = 2'(ST_RESP);

    // Elaboration guards: the latched-request struct is sized by the package.
    if (DATA_WIDTH != BR_DATA_W || ADDR_WIDTH != BR_ADDR_W || REGION_BITS != BR_REGION_W) begin : g_bad_width
        $error("apb_slave_bridge_mc: widths must match apb_bridge_pkg BR_* values");
    end
    if (NUM_CH < 1 || NUM_CH > 16 || CH_BITS(NUM_CH) > BR_CH_FIELD_W) begin : g_bad_num_ch
        $error("apb_slave_bridge_mc: NUM_CH out of range");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_slave_bridge_mc: TIMEOUT_CYCLES must be at least 1");
    end

    logic [1:0]               state_q, state_d;
    bridge_req_t              req_q;
    logic                     err_q;
    logic [DATA_WIDTH-1:0]    rdata_q;
    logic [BR_CH_FIELD_W-1:0] dec_ch;
    logic                     setup, ch_ok, in_flight, timeout;
    logic [NUM_CH-1:0]        act_mask;
    logic                     sel_ready, sel_error;
    logic [DATA_WIDTH-1:0]    sel_rdata;

    assign dec_ch    = apb.PADDR[ADDR_WIDTH-1:REGION_BITS];
    assign setup     = apb.PSELx && !apb.PENABLE;
    assign ch_ok     = int'(dec_ch) < NUM_CH;
    assign in_flight = (state_q == S_REQ) || (state_q == S_WAIT);

    // Active-channel mask; responses on any other channel are masked off.
    always_comb begin
        act_mask  = '0;
        sel_rdata = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (req_q.ch == BR_CH_FIELD_W'(c)) begin
                act_mask[c] = 1'b1;
                sel_rdata   = bk_rdata[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign sel_ready = |(bk_ready & act_mask);
    assign sel_error = |(bk_error & act_mask);

`ifdef APB_BRIDGE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    apb_timeout_ctr #(.W(TO_W)) u_timeout (
        .clk     (PCLK),
        .rst     (PRESET),
        .clear   (!in_flight),
        .enable  (in_flight),
        .limit   (TO_W'(TIMEOUT_CYCLES)),
        .expired (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (setup) state_d = ch_ok ? S_REQ : S_RESP;
            S_REQ, S_WAIT: begin
                // Dropping PSELx mid-transfer abandons it with no response.
                if (!apb.PSELx)     state_d = S_IDLE;
                else if (sel_ready) state_d = S_RESP;
                else if (timeout)   state_d = S_RESP;
                else                state_d = S_WAIT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= S_IDLE;
            req_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (setup) begin
                        req_q.addr  <= apb.PADDR[REGION_BITS-1:0];
                        req_q.write <= apb.PWRITE;
                        req_q.wdata <= apb.PWDATA;
                        req_q.strb  <= apb.PSTRB;
                        req_q.ch    <= dec_ch;
                        err_q       <= !ch_ok;
                        rdata_q     <= '0;
                    end
                end
                S_REQ, S_WAIT: begin
                    if (apb.PSELx) begin
                        // bk_ready has priority over a same-cycle timeout.
                        if (sel_ready) begin
                            err_q   <= sel_error;
                            rdata_q <= (!req_q.write && !sel_error) ? sel_rdata : '0;
                        end else if (timeout) begin
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bk_wr_en    = (state_q == S_REQ &&  req_q.write) ? act_mask : '0;
    assign bk_rd_en    = (state_q == S_REQ && !req_q.write) ? act_mask : '0;
    assign bk_addr     = req_q.addr;
    assign bk_wdata    = req_q.wdata;
    assign bk_strb     = req_q.strb;

    assign apb.PREADY  = (state_q == S_RESP);
    assign apb.PSLVERR = (state_q == S_RESP) && err_q;
    assign apb.PRDATA  = (state_q == S_RESP) ? rdata_q : '0;

    assign dbg_state   = state_q;
endmodule

// File: tb/tb_apb_slave_bridge_mc.sv
module tb_apb_slave_bridge_mc;
    localparam int DW  = 32;
    localparam int AW  = 12;
    localparam int NCH = 3;
    localparam int RB  = 8;
    localparam int TO  = 16;
    localparam int SW  = DW / 8;
    localparam logic [1:0] IDLE_ST = 2'd0;
    localparam int NEVER = 1000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    apb_slave_bridge_mc_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) apb ();

    logic [NCH-1:0]    bk_wr_en, bk_rd_en, bk_ready, bk_error;
    logic [RB-1:0]     bk_addr;
    logic [DW-1:0]     bk_wdata;
    logic [SW-1:0]     bk_strb;
    logic [NCH*DW-1:0] bk_rdata;
    logic [1:0]        dbg_state;

    apb_slave_bridge_mc #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NCH),
        .REGION_BITS(RB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK(clk), .PRESET(rst), .apb(apb),
        .bk_wr_en(bk_wr_en), .bk_rd_en(bk_rd_en), .bk_addr(bk_addr),
        .bk_wdata(bk_wdata), .bk_strb(bk_strb), .bk_rdata(bk_rdata),
        .bk_ready(bk_ready), .bk_error(bk_error), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_err    = 0;
    logic [DW:0] exp_q[$];   // {PSLVERR, PRDATA} per completed transfer

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Active channel gets the directed response; all other channels toggle
    // randomly and must be ignored by the bridge.
    task automatic drive_backend(input int ch, input logic rdy, input logic err, input logic [DW-1:0] rd);
        for (int c = 0; c < NCH; c++) begin
            if (c == ch) begin
                bk_ready[c] = rdy;
                bk_error[c] = err;
                bk_rdata[c*DW +: DW] = rd;
            end else begin
                bk_ready[c] = 1'($urandom_range(0, 1));
                bk_error[c] = 1'($urandom_range(0, 1));
                bk_rdata[c*DW +: DW] = $urandom;
            end
        end
    endtask

    task automatic bus_idle();
        apb.PSELx = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
        apb.PADDR = '0; apb.PWDATA = '0; apb.PSTRB = '0;
        bk_ready = '0; bk_error = '0; bk_rdata = '0;
    endtask

    // Full APB transfer. d = REQ/WAIT cycles without bk_ready before the ready
    // cycle; exp_err forces an expected error (timeout case).
    task automatic xfer(input string tag, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [SW-1:0] strb, input int d,
                        input logic be_err, input logic [DW-1:0] be_rdata,
                        input logic force_err, input int exp_lat);
        int ch;
        logic dec_err, exp_err, done;
        logic [DW-1:0] exp_data;
        logic [NCH-1:0] exp_en;
        logic [DW:0] exp_resp;
        int t;
        ch       = int'(addr[AW-1:RB]);
        dec_err  = (ch >= NCH);
        exp_err  = dec_err || be_err || force_err;
        exp_data = (!wr && !exp_err) ? be_rdata : '0;
        exp_en   = dec_err ? '0 : NCH'(1 << ch);
        exp_q.push_back({exp_err, exp_data});

        apb.PSELx = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = wr;
        apb.PADDR = addr; apb.PWDATA = wdata; apb.PSTRB = strb;
        drive_backend(dec_err ? -1 : ch, 1'b0, be_err, be_rdata);
        @(posedge clk); #1;
        apb.PENABLE = 1'b1;
        t = 1;
        done = 1'b0;
        while (!done && t <= 60) begin
            drive_backend(dec_err ? -1 : ch, (t == 1 + d), be_err, be_rdata);
            @(negedge clk);
            if (t == 1) begin
                chk({tag, "_wr_en"}, 64'(bk_wr_en), 64'(wr ? exp_en : '0));
                chk({tag, "_rd_en"}, 64'(bk_rd_en), 64'(wr ? '0 : exp_en));
                chk({tag, "_bk_addr"}, 64'(bk_addr), 64'(addr[RB-1:0]));
                chk({tag, "_bk_wdata"}, 64'(bk_wdata), 64'(wdata));
                chk({tag, "_bk_strb"}, 64'(bk_strb), 64'(strb));
            end else begin
                chk({tag, "_en_pulse"}, 64'({bk_wr_en, bk_rd_en}), 64'(0));
            end
            if (apb.PREADY) begin
                chk({tag, "_latency"}, 64'(t), 64'(exp_lat));
                exp_resp = exp_q.pop_front();
                chk({tag, "_resp"}, 64'({apb.PSLVERR, apb.PRDATA}), 64'(exp_resp));
                done = 1'b1;
            end else begin
                chk({tag, "_quiet"}, 64'({apb.PSLVERR, apb.PRDATA}), 64'(0));
            end
            @(posedge clk); #1;
            t++;
        end
        if (!done) begin
            chk({tag, "_pready_seen"}, 64'(apb.PREADY), 64'(1));
            void'(exp_q.pop_front());
        end
        apb.PSELx = 1'b0; apb.PENABLE = 1'b0;
        bk_ready = '0;
    endtask

    // Start a transfer that the back-end never answers, run n cycles into it.
    task automatic start_silent(input logic wr, input logic [AW-1:0] addr, input int n);
        apb.PSELx = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = wr;
        apb.PADDR = addr; apb.PWDATA = 32'hDEAD_BEEF; apb.PSTRB = 4'hF;
        bk_ready = '0;
        @(posedge clk); #1;
        apb.PENABLE = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("silent_no_pready", 64'(apb.PREADY), 64'(0));
            @(posedge clk); #1;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bus_idle();
        rst = 1'b1;
        #1;
        chk("reset_outputs", 64'({apb.PREADY, apb.PSLVERR, bk_wr_en, bk_rd_en}), 64'(0));
        chk("reset_prdata", 64'(apb.PRDATA), 64'(0));
        chk("reset_bk_latches", 64'({bk_addr, bk_strb}), 64'(0));
        chk("reset_bk_wdata", 64'(bk_wdata), 64'(0));
        chk("reset_state", 64'(dbg_state), 64'(IDLE_ST));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Write to ch1, ready in REQ: minimum one wait state.
        xfer("wr_ch1", 1'b1, 12'h104, 32'hA5A5_0001, 4'hF, 0, 1'b0, '0, 1'b0, 2);
        // Read from ch2, three wait cycles before bk_ready.
        xfer("rd_ch2", 1'b0, 12'h208, 32'h0, 4'h0, 3, 1'b0, 32'h1234_5678, 1'b0, 5);
        // Decode error: channel 3 with only 3 channels.
        xfer("dec_err", 1'b0, 12'h300, 32'h0, 4'h0, 0, 1'b0, '0, 1'b0, 1);
        // Back-end error on read, then a back-to-back write.
        xfer("rd_be_err", 1'b0, 12'h010, 32'h0, 4'h0, 0, 1'b1, 32'hFFFF_FFFF, 1'b0, 2);
        xfer("b2b_wr", 1'b1, 12'h0FC, 32'hCAFE_F00D, 4'h5, 1, 1'b0, '0, 1'b0, 3);

        // Randomised transfers over the valid channels.
        for (int i = 0; i < 6; i++) begin
            logic wr;
            logic [AW-1:0] a;
            int d;
            wr = 1'($urandom_range(0, 1));
            a  = {4'($urandom_range(0, NCH - 1)), 8'($urandom_range(0, 255))};
            d  = $urandom_range(0, 4);
            xfer("rand", wr, a, $urandom, 4'($urandom_range(0, 15)), d,
                 1'($urandom_range(0, 1)), $urandom, 1'b0, 2 + d);
        end

`ifdef APB_BRIDGE_TIMEOUT_EN
        // Silent back-end: error after TO REQ/WAIT cycles.
        xfer("timeout", 1'b0, 12'h180, 32'h0, 4'h0, NEVER, 1'b0, 32'h5555_AAAA, 1'b1, TO + 1);
        // bk_ready on the limit cycle wins.
        xfer("ready_at_limit", 1'b0, 12'h180, 32'h0, 4'h0, TO - 1, 1'b0, 32'h5555_AAAA, 1'b0, TO + 1);
`endif

        // Abort: PSELx dropped in WAIT, late bk_ready ignored.
        start_silent(1'b0, 12'h220, 8);
        apb.PSELx = 1'b0; apb.PENABLE = 1'b0;
        @(posedge clk); #1;
        bk_ready = 3'b111;
        bk_error = 3'b111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_state", 64'(dbg_state), 64'(IDLE_ST));
            chk("abort_outputs", 64'({apb.PREADY, apb.PSLVERR, bk_wr_en, bk_rd_en}), 64'(0));
            @(posedge clk); #1;
        end
        bus_idle();
        xfer("after_abort", 1'b0, 12'h024, 32'h0, 4'h0, 1, 1'b0, 32'h0BAD_F00D, 1'b0, 3);

        // Reset mid-WAIT: outputs clear immediately.
        start_silent(1'b1, 12'h1AC, 3);
        #2 rst = 1'b1;
        #1;
        chk("rst_wait_outputs", 64'({apb.PREADY, apb.PSLVERR, bk_wr_en, bk_rd_en}), 64'(0));
        chk("rst_wait_prdata", 64'(apb.PRDATA), 64'(0));
        chk("rst_wait_latches", 64'({bk_addr, bk_strb}), 64'(0));
        chk("rst_wait_wdata", 64'(bk_wdata), 64'(0));
        chk("rst_wait_state", 64'(dbg_state), 64'(IDLE_ST));
        bus_idle();
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        xfer("after_reset", 1'b0, 12'h1F0, 32'h0, 4'h0, 2, 1'b0, 32'h7654_3210, 1'b0, 4);

        chk("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end
endmodule
